cam_pipelined: RTL and testbench
================================

# cam_pipelined

Parametrised, pipelined content-addressable memory with per-entry valid bits, addressed write, invalidate and auto-insert into the lowest free slot. A search returns the lowest-index matching entry, a hit flag and a multi-hit flag two cycles after issue, at one search per cycle. It sits between the lookup requester and table-management logic and replaces the fixed 16x8, purely combinational CAM.

## Interface
- DATA_W, 8, width of stored words and search key
- DEPTH, 16, number of entries; must be at least 2
- ADDR_W, $clog2(DEPTH), width of entry index
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  addressed write: entry wr_addr <= wr_data, valid set
- wr_addr  in  ADDR_W  write index; values >= DEPTH are ignored, no state change
- wr_data  in  DATA_W  write word
- del_en  in  1  invalidate entry del_addr; stored data is kept, valid cleared
- del_addr  in  ADDR_W  invalidate index; values >= DEPTH are ignored
- ins_en  in  1  insert ins_data at the lowest-index invalid entry
- ins_data  in  DATA_W  insert word
- ins_ack  out  1  registered; 1-cycle pulse, insert accepted
- ins_fail  out  1  registered; 1-cycle pulse, insert rejected (table full or lost arbitration)
- ins_addr  out  ADDR_W  registered; slot used by the accepted insert, valid only with ins_ack
- srch_en  in  1  issue a search with srch_data
- srch_data  in  DATA_W  search key
- srch_vld  out  1  registered; result valid this cycle
- found  out  1  at least one valid entry matched
- multi  out  1  two or more valid entries matched
- srch_addr  out  ADDR_W  lowest matching index; 0 when found=0
- count  out  ADDR_W+1  number of valid entries
- full  out  1  count == DEPTH

## Operation
- Reset drives every data word, valid bit and pipeline register to 0 and every output to 0: count=0, full=0, srch_vld=0, found=0, multi=0, srch_addr=0, ins_ack=0, ins_fail=0, ins_addr=0.
- At most one table update is performed per cycle. Priority is wr_en > del_en > ins_en; lower-priority requests in the same cycle are dropped.
- A dropped ins_en pulses ins_fail. A dropped del_en gives no indication.
- Write to an entry that is already valid: data overwritten, count unchanged. Write to an invalid entry: count+1.
- Invalidate of a valid entry: count-1. Invalidate of an invalid entry: no-op.
- Insert: the free slot is the lowest-index entry with valid=0, taken from the state before the edge.
  - If a slot exists: write data, set valid, count+1, pulse ins_ack with ins_addr.
  - If full: no change, pulse ins_fail.
- Duplicate values are allowed; neither insert nor write checks for an existing match.
- Search compares only valid entries. Invalid entries never match, even if their data equals the key.

## Timing
- Stage 1, at the edge ending cycle T with srch_en=1:
  - Compare srch_data against the table contents present before that edge.
  - Register the DEPTH-bit match vector.
  - An update at the same edge is not visible to this search; it is visible to a search issued in T+1.
- Stage 2, at the next edge:
  - Priority-encode the match vector (lowest index wins).
  - Register found, multi and srch_addr.
  - srch_vld=1 during cycle T+2.
- Throughput is one search per cycle, with no stalls and no backpressure.
- srch_vld is 0 in any cycle without a completing search. found, multi and srch_addr hold their last values when srch_vld=0.
- ins_ack, ins_fail and ins_addr are registered at the same edge that performs the insert (1-cycle latency).
- count and full are registered and update at the same edge as the table change.
- rst asserted mid-operation flushes both search stages. No srch_vld pulse is produced for searches in flight.

## Test plan
- Reset, then search key 0x00 -> srch_vld two cycles later with found=0, multi=0, srch_addr=0, count=0.
- Write 0xA5 at 3 and 0xA5 at 9, then search 0xA5 -> found=1, multi=1, srch_addr=3. Invalidate 3 and search again -> found=1, multi=0, srch_addr=9, count=1.
- Insert 0x10..0x1F on an empty DEPTH=16 table -> ins_ack with ins_addr 0..15, full=1 after the 16th. A 17th insert -> ins_fail=1, count stays 16.
- Same cycle: wr_en to 5, del_en to 2, ins_en -> only entry 5 written, entry 2 still valid, ins_fail pulses.
- Write 0x42 at 7 and search 0x42 in the same cycle -> found=0. A search issued the next cycle -> found=1, srch_addr=7. Back-to-back searches every cycle -> one srch_vld per search, in issue order.
- Assert rst with two searches in flight -> no srch_vld afterwards, all outputs 0. Parameter sweep DATA_W=32, DEPTH=64 repeats the insert/full scenario.

Source files
------------

// File: rtl/cam_pipelined_if.sv
// Bundle of table-update, insert and search signals for cam_pipelined.
// The master drives requests; the slave (the CAM) drives results.
interface cam_pipelined_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              del_en;
    logic [ADDR_W-1:0] del_addr;
    logic              ins_en;
    logic [DATA_W-1:0] ins_data;
    logic              ins_ack;
    logic              ins_fail;
    logic [ADDR_W-1:0] ins_addr;
    logic              srch_en;
    logic [DATA_W-1:0] srch_data;
    logic              srch_vld;
    logic              found;
    logic              multi;
    logic [ADDR_W-1:0] srch_addr;
    logic [ADDR_W:0]   count;
    logic              full;

    modport master (
        output wr_en, wr_addr, wr_data, del_en, del_addr, ins_en, ins_data,
               srch_en, srch_data,
        input  ins_ack, ins_fail, ins_addr, srch_vld, found, multi, srch_addr,
               count, full
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, del_en, del_addr, ins_en, ins_data,
               srch_en, srch_data,
        output ins_ack, ins_fail, ins_addr, srch_vld, found, multi, srch_addr,
               count, full
    );
endinterface

// File: rtl/cam_pipelined.sv
// Pipelined CAM: one table update per cycle (write > invalidate > insert) and a
// two-stage search (compare, then priority encode) at one search per cycle.
module cam_pipelined #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    cam_pipelined_if.slave bus
);
    localparam logic [ADDR_W:0]  DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [DEPTH-1:0] MATCH_ONE = DEPTH'(1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              ins_ack_q, ins_ack_d;
    logic              ins_fail_q, ins_fail_d;
    logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              free_any;
    logic [ADDR_W-1:0] free_idx;
    logic              wr_ok, del_ok;

    logic [DEPTH-1:0]  match_d, match_q;
    logic              s1_vld_q;
    logic              srch_vld_q, found_q, multi_q;
    logic              multi_d;
    logic [ADDR_W-1:0] hit_idx, srch_addr_q;

    // Out-of-range indices only exist when DEPTH is not a power of two.
    assign wr_ok  = ({1'b0, bus.wr_addr}  < DEPTH_C);
    assign del_ok = ({1'b0, bus.del_addr} < DEPTH_C);

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = ADDR_W'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        valid_d    = valid_q;
        count_d    = count_q;
        mem_we     = 1'b0;
        mem_addr   = bus.wr_addr;
        mem_data   = bus.wr_data;
        ins_ack_d  = 1'b0;
        ins_fail_d = 1'b0;
        ins_addr_d = ins_addr_q;
        if (bus.wr_en) begin
            if (wr_ok) begin
                mem_we                = 1'b1;
                valid_d[bus.wr_addr]  = 1'b1;
                if (!valid_q[bus.wr_addr]) count_d = count_q + CNT_ONE;
            end
            ins_fail_d = bus.ins_en;
        end else if (bus.del_en) begin
            if (del_ok && valid_q[bus.del_addr]) begin
                valid_d[bus.del_addr] = 1'b0;
                count_d               = count_q - CNT_ONE;
            end
            ins_fail_d = bus.ins_en;
        end else if (bus.ins_en) begin
            if (free_any) begin
                mem_we            = 1'b1;
                mem_addr          = free_idx;
                mem_data          = bus.ins_data;
                valid_d[free_idx] = 1'b1;
                count_d           = count_q + CNT_ONE;
                ins_ack_d         = 1'b1;
                ins_addr_d        = free_idx;
            end else begin
                ins_fail_d = 1'b1;
            end
        end
        full_d = (count_d == DEPTH_C);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_d[i] = valid_q[i] && (data_q[i] == bus.srch_data);
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_q[i]) hit_idx = ADDR_W'(i);
        end
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_d = ((match_q & (match_q - MATCH_ONE)) != '0);
    end

    // NOTE: state uses <= so each register samples pre-edge values; this is what
    // keeps a same-edge table update invisible to the search compared at that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the table words are reset too, because reset defines them all as 0.
            data_q      <= '{default: '0};
            valid_q     <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ins_ack_q   <= 1'b0;
            ins_fail_q  <= 1'b0;
            ins_addr_q  <= '0;
            match_q     <= '0;
            s1_vld_q    <= 1'b0;
            srch_vld_q  <= 1'b0;
            found_q     <= 1'b0;
            multi_q     <= 1'b0;
            srch_addr_q <= '0;
        end else begin
            if (mem_we) data_q[mem_addr] <= mem_data;
            valid_q    <= valid_d;
            count_q    <= count_d;
            full_q     <= full_d;
            ins_ack_q  <= ins_ack_d;
            ins_fail_q <= ins_fail_d;
            ins_addr_q <= ins_addr_d;

            s1_vld_q <= bus.srch_en;
            if (bus.srch_en) match_q <= match_d;

            srch_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                found_q     <= |match_q;
                multi_q     <= multi_d;
                srch_addr_q <= hit_idx;
            end
        end
    end

    assign bus.ins_ack   = ins_ack_q;
    assign bus.ins_fail  = ins_fail_q;
    assign bus.ins_addr  = ins_addr_q;
    assign bus.srch_vld  = srch_vld_q;
    assign bus.found     = found_q;
    assign bus.multi     = multi_q;
    assign bus.srch_addr = srch_addr_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
endmodule

// File: tb/tb_cam_pipelined.sv
// Directed bench for cam_pipelined: a 16x8 instance for the functional scenarios
// and a 64x32 instance for the insert-until-full sweep.
module tb_cam_pipelined;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] keys  [4];
    logic       exp_f [4];
    logic [3:0] exp_a [4];

    cam_pipelined_if #(.DATA_W(8),  .DEPTH(16)) bus   ();
    cam_pipelined_if #(.DATA_W(32), .DEPTH(64)) bus_w ();

    cam_pipelined #(.DATA_W(8), .DEPTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cam_pipelined #(.DATA_W(32), .DEPTH(64)) u_dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic del(input logic [3:0] addr);
        bus.del_en = 1'b1; bus.del_addr = addr;
        tick();
        bus.del_en = 1'b0;
    endtask

    task automatic search_chk(input string tag, input logic [7:0] key,
                              input logic ef, input logic em, input logic [3:0] ea);
        bus.srch_en = 1'b1; bus.srch_data = key;
        tick();
        bus.srch_en = 1'b0;
        check({tag, ".vld_early"}, bus.srch_vld, 0);
        tick();
        check({tag, ".vld"},   bus.srch_vld, 1);
        check({tag, ".found"}, bus.found, ef);
        check({tag, ".multi"}, bus.multi, em);
        check({tag, ".addr"},  bus.srch_addr, ea);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.del_en = 0; bus.del_addr = 0;
        bus.ins_en = 0; bus.ins_data = 0;
        bus.srch_en = 0; bus.srch_data = 0;
        bus_w.wr_en = 0; bus_w.wr_addr = 0; bus_w.wr_data = 0;
        bus_w.del_en = 0; bus_w.del_addr = 0;
        bus_w.ins_en = 0; bus_w.ins_data = 0;
        bus_w.srch_en = 0; bus_w.srch_data = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst.count", bus.count, 0);
        check("rst.full", bus.full, 0);
        check("rst.srch_vld", bus.srch_vld, 0);
        check("rst.found", bus.found, 0);
        check("rst.multi", bus.multi, 0);
        check("rst.srch_addr", bus.srch_addr, 0);
        check("rst.ins_ack", bus.ins_ack, 0);
        check("rst.ins_fail", bus.ins_fail, 0);
        check("rst.ins_addr", bus.ins_addr, 0);
        search_chk("empty", 8'h00, 0, 0, 0);
        check("empty.count", bus.count, 0);

        // Duplicate match, then invalidate the lower one
        wr(4'd3, 8'hA5);
        wr(4'd9, 8'hA5);
        check("dup.count", bus.count, 2);
        search_chk("dup", 8'hA5, 1, 1, 3);
        del(4'd3);
        check("del.count", bus.count, 1);
        search_chk("after_del", 8'hA5, 1, 0, 9);

        // Fill by insert
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("fill.count0", bus.count, 0);
        for (int i = 0; i < 16; i++) begin
            bus.ins_en = 1'b1; bus.ins_data = 8'(8'h10 + i);
            tick();
            check("fill.ack", bus.ins_ack, 1);
            check("fill.fail", bus.ins_fail, 0);
            check("fill.addr", bus.ins_addr, 64'(i));
            check("fill.count", bus.count, 64'(i + 1));
            check("fill.full", bus.full, (i == 15) ? 1 : 0);
        end
        bus.ins_data = 8'h20;
        tick();
        bus.ins_en = 1'b0;
        check("overflow.fail", bus.ins_fail, 1);
        check("overflow.ack", bus.ins_ack, 0);
        check("overflow.count", bus.count, 16);
        check("overflow.full", bus.full, 1);
        tick();
        check("overflow.fail_pulse", bus.ins_fail, 0);

        // Arbitration: write wins, invalidate and insert dropped
        del(4'd10);
        check("arb.count_pre", bus.count, 15);
        check("arb.full_pre", bus.full, 0);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'h55;
        bus.del_en = 1'b1; bus.del_addr = 4'd2;
        bus.ins_en = 1'b1; bus.ins_data = 8'h77;
        tick();
        bus.wr_en = 1'b0; bus.del_en = 1'b0; bus.ins_en = 1'b0;
        check("arb.ins_fail", bus.ins_fail, 1);
        check("arb.ins_ack", bus.ins_ack, 0);
        check("arb.count", bus.count, 15);
        search_chk("arb.ins_dropped", 8'h77, 0, 0, 0);
        search_chk("arb.entry2", 8'h12, 1, 0, 2);
        search_chk("arb.entry5", 8'h55, 1, 0, 5);
        search_chk("arb.old5", 8'h15, 0, 0, 0);
        bus.ins_en = 1'b1; bus.ins_data = 8'h88;
        tick();
        bus.ins_en = 1'b0;
        check("lowfree.ack", bus.ins_ack, 1);
        check("lowfree.addr", bus.ins_addr, 10);
        check("lowfree.full", bus.full, 1);

        // Same-edge write is invisible to that search, visible to the next
        bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 8'h42;
        bus.srch_en = 1'b1; bus.srch_data = 8'h42;
        tick();
        bus.wr_en = 1'b0;
        tick();
        bus.srch_en = 1'b0;
        check("hazard.vld0", bus.srch_vld, 1);
        check("hazard.found0", bus.found, 0);
        tick();
        check("hazard.vld1", bus.srch_vld, 1);
        check("hazard.found1", bus.found, 1);
        check("hazard.addr1", bus.srch_addr, 7);
        tick();
        check("hazard.idle", bus.srch_vld, 0);

        // Back-to-back searches, results in issue order
        keys[0] = 8'h12; exp_f[0] = 1'b1; exp_a[0] = 4'd2;
        keys[1] = 8'h99; exp_f[1] = 1'b0; exp_a[1] = 4'd0;
        keys[2] = 8'h55; exp_f[2] = 1'b1; exp_a[2] = 4'd5;
        keys[3] = 8'h88; exp_f[3] = 1'b1; exp_a[3] = 4'd10;
        for (int j = 0; j < 6; j++) begin
            bus.srch_en = (j < 4);
            bus.srch_data = keys[(j < 4) ? j : 0];
            tick();
            if (j >= 1 && j <= 4) begin
                check("b2b.vld", bus.srch_vld, 1);
                check("b2b.found", bus.found, exp_f[j-1]);
                check("b2b.addr", bus.srch_addr, exp_a[j-1]);
                check("b2b.multi", bus.multi, 0);
            end else begin
                check("b2b.idle", bus.srch_vld, 0);
            end
        end

        // Asynchronous reset with searches in flight
        bus.srch_en = 1'b1; bus.srch_data = 8'h12;
        tick();
        bus.srch_data = 8'h55;
        #2 rst = 1'b1;
        bus.srch_en = 1'b0;
        #1;
        check("flush.async_count", bus.count, 0);
        check("flush.async_vld", bus.srch_vld, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush.vld", bus.srch_vld, 0);
        end
        check("flush.found", bus.found, 0);
        check("flush.multi", bus.multi, 0);
        check("flush.addr", bus.srch_addr, 0);
        check("flush.full", bus.full, 0);
        check("flush.ins_addr", bus.ins_addr, 0);

        // Wide instance: DATA_W=32, DEPTH=64
        for (int i = 0; i < 64; i++) begin
            bus_w.ins_en = 1'b1; bus_w.ins_data = 32'hC0DE_0000 | 32'(i);
            tick();
            check("wide.ack", bus_w.ins_ack, 1);
            check("wide.addr", bus_w.ins_addr, 64'(i));
        end
        check("wide.count", bus_w.count, 64);
        check("wide.full", bus_w.full, 1);
        bus_w.ins_data = 32'hDEAD_BEEF;
        tick();
        bus_w.ins_en = 1'b0;
        check("wide.overflow_fail", bus_w.ins_fail, 1);
        check("wide.overflow_count", bus_w.count, 64);
        bus_w.srch_en = 1'b1; bus_w.srch_data = 32'hC0DE_0020;
        tick();
        bus_w.srch_en = 1'b0;
        tick();
        check("wide.srch_vld", bus_w.srch_vld, 1);
        check("wide.found", bus_w.found, 1);
        check("wide.srch_addr", bus_w.srch_addr, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
